// File: rtl/scmp_microcode_pak.sv
// Shared SC/MP microcode package: entry labels, opcode decode helpers and the
// decoded-instruction entry layout used by the opcode decode queue.
// Latency: pure types/functions, no state. Backpressure: n/a.
// Optional macro SCMP_OPDEC_ILLEGAL_EN adds a per-entry illegal-opcode flag.
package scmp_microcode_pak;

   // Microcode entry labels. FETCH must stay at encoding zero so that an
   // all-zero (empty) queue slot reads back as FETCH.
   typedef enum logic [4:0] {
      UCLBL_FETCH = 5'd0,
      UCLBL_HALT,
      UCLBL_DLY,
      UCLBL_XAE,
      UCLBL_ST,
      UCLBL_DAD,
      UCLBL_LD,
      UCLBL_DAE,
      UCLBL_LDE,
      UCLBL_ILD,
      UCLBL_DLD,
      UCLBL_JMP,
      UCLBL_XPAL,
      UCLBL_XPAH,
      UCLBL_CL
   } NEXTPC_t;

   // Assembler states: waiting for an opcode, or for its displacement.
   typedef enum logic {
      S_OP   = 1'b0,
      S_DISP = 1'b1
   } asm_state_t;

   // One decoded instruction as held in the queue (address kept alongside,
   // since its width is a per-instance parameter).
   typedef struct packed {
      logic [7:0] op;
      logic [7:0] disp;
      logic       len2;
      NEXTPC_t    pc;
`ifdef SCMP_OPDEC_ILLEGAL_EN
      logic       illegal;
`endif
   } scmp_opdec_ent_t;

   // Opcode to microcode entry label. Patterns overlap (e.g. 0x68 also fits
   // the LDE pattern, 0xCC fits the LD pattern), so order matters.
   function automatic NEXTPC_t scmp_op_label(input logic [7:0] op);
      NEXTPC_t lbl;
      if (op == 8'h00)                                lbl = UCLBL_HALT;
      else if (op == 8'h8F)                           lbl = UCLBL_DLY;
      else if (op == 8'h01)                           lbl = UCLBL_XAE;
      else if ((op ==? 8'b11001???) && (op[2:0] != 3'b100))
                                                      lbl = UCLBL_ST;
      else if (op ==? 8'b11101???)                    lbl = UCLBL_DAD;
      else if (op ==? 8'b11??????)                    lbl = UCLBL_LD;
      else if (op == 8'h68)                           lbl = UCLBL_DAE;
      else if (op ==? 8'b01???000)                    lbl = UCLBL_LDE;
      else if (op ==? 8'b101010??)                    lbl = UCLBL_ILD;
      else if (op ==? 8'b101110??)                    lbl = UCLBL_DLD;
      else if (op ==? 8'b1001????)                    lbl = UCLBL_JMP;
      else if (op ==? 8'b001100??)                    lbl = UCLBL_XPAL;
      else if (op ==? 8'b001101??)                    lbl = UCLBL_XPAH;
      else if (op ==? 8'b0000001?)                    lbl = UCLBL_CL;
      else                                            lbl = UCLBL_FETCH;
      return lbl;
   endfunction

   // Bit 7 of the opcode marks a two-byte (displacement-carrying) instruction.
   function automatic logic scmp_op_is2(input logic [7:0] op);
      return op[7];
   endfunction

endpackage

// File: rtl/scmp_opdec_asm.sv
// Groups fetched bytes into 1/2-byte instructions and emits one decoded entry
// per complete instruction. Latency: entry strobe is combinational in the cycle
// the final byte is accepted. Backpressure: caller gates 'accept'; none here.
// Ports: clk, rst (sync, active high), flush, accept (byte taken this cycle),
//        data/addr (byte and its address), wr/ent/ent_addr (entry write).
// Optional macro SCMP_OPDEC_ILLEGAL_EN fills the entry's illegal flag.
module scmp_opdec_asm
   import scmp_microcode_pak::*;
#(
   parameter int AW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            accept,
   input  logic [7:0]      data,
   input  logic [AW-1:0]   addr,
   output logic            wr,
   output scmp_opdec_ent_t ent,
   output logic [AW-1:0]   ent_addr
);

   asm_state_t    state, state_nx;
   logic [7:0]    op_q;
   logic [AW-1:0] addr_q;
   logic [7:0]    op_w;
   logic [7:0]    disp_w;
   logic          len2_w;

   // Reset and flush both drop any half-assembled instruction.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state  <= S_OP;
         op_q   <= '0;
         addr_q <= '0;
      end else begin
         state <= state_nx;
         if (accept && (state == S_OP) && scmp_op_is2(data)) begin
            op_q   <= data;
            addr_q <= addr;
         end
      end
   end

   always_comb begin
      state_nx = state;
      wr       = 1'b0;
      op_w     = data;
      disp_w   = 8'h00;
      len2_w   = 1'b0;
      ent_addr = addr;
      case (state)
         S_OP: begin
            if (accept) begin
               if (scmp_op_is2(data)) state_nx = S_DISP;
               else                   wr       = 1'b1;
            end
         end
         S_DISP: begin
            if (accept) begin
               wr       = 1'b1;
               op_w     = op_q;
               disp_w   = data;
               len2_w   = 1'b1;
               ent_addr = addr_q;
               state_nx = S_OP;
            end
         end
         default: state_nx = S_OP;
      endcase
   end

   always_comb begin
      ent      = '0;
      ent.op   = op_w;
      ent.disp = disp_w;
      ent.len2 = len2_w;
      ent.pc   = scmp_op_label(op_w);
`ifdef SCMP_OPDEC_ILLEGAL_EN
      // NOP (0x08) legitimately decodes to FETCH; anything else landing there is unknown.
      ent.illegal = (scmp_op_label(op_w) == UCLBL_FETCH) && (op_w != 8'h08);
`endif
   end

endmodule

// File: rtl/scmp_opdec_queue.sv
// SC/MP instruction assembler plus DEPTH-entry decoded-instruction queue.
// Latency: entry visible on dec_valid the cycle after its last byte is accepted.
// Backpressure: fetch_ready drops when the queue is full (no same-cycle bypass).
// Ports: clk, rst (sync, active high), flush; fetch_valid/fetch_ready/
//        fetch_byte/fetch_addr in; dec_valid/dec_ready/dec_op/dec_disp/
//        dec_addr/dec_len2/dec_pc out (head entry, shown ahead).
// Optional macro SCMP_OPDEC_ILLEGAL_EN adds output dec_illegal.
module scmp_opdec_queue
   import scmp_microcode_pak::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          fetch_valid,
   output logic          fetch_ready,
   input  logic [7:0]    fetch_byte,
   input  logic [AW-1:0] fetch_addr,
   output logic          dec_valid,
   input  logic          dec_ready,
   output logic [7:0]    dec_op,
   output logic [7:0]    dec_disp,
   output logic [AW-1:0] dec_addr,
   output logic          dec_len2,
   output NEXTPC_t       dec_pc
`ifdef SCMP_OPDEC_ILLEGAL_EN
   ,
   output logic          dec_illegal
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   scmp_opdec_ent_t mem      [DEPTH];
   logic [AW-1:0]   mem_addr [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;

   logic            accept;
   logic            pop;
   logic            wr;
   scmp_opdec_ent_t wr_ent;
   logic [AW-1:0]   wr_addr;
   scmp_opdec_ent_t head;

   assign fetch_ready = !rst && !flush && (count < DEPTH_C);
   assign accept      = fetch_valid && fetch_ready;
   assign dec_valid   = (count != '0);
   assign pop         = dec_valid && dec_ready && !flush;

   scmp_opdec_asm #(.AW(AW)) u_asm (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .accept   (accept),
      .data     (fetch_byte),
      .addr     (fetch_addr),
      .wr       (wr),
      .ent      (wr_ent),
      .ent_addr (wr_addr)
   );

   // Storage is cleared on reset so the empty head reads as zero / FETCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i]      <= '0;
            mem_addr[i] <= '0;
         end
      end else if (wr) begin
         mem[wr_ptr]      <= wr_ent;
         mem_addr[wr_ptr] <= wr_addr;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head     = mem[rd_ptr];
   assign dec_op   = head.op;
   assign dec_disp = head.disp;
   assign dec_len2 = head.len2;
   assign dec_pc   = head.pc;
   assign dec_addr = mem_addr[rd_ptr];
`ifdef SCMP_OPDEC_ILLEGAL_EN
   assign dec_illegal = head.illegal;
`endif

endmodule

// File: tb/tb_scmp_opdec_queue.sv
// Self-checking bench for scmp_opdec_queue (DEPTH=2, AW=16): a reference
// assembler/decoder pushes expected entries on byte acceptance, and they are
// popped and compared when the DUT hands an entry to the sequencer.
module tb_scmp_opdec_queue;
   import scmp_microcode_pak::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        fetch_valid = 1'b0;
   logic        fetch_ready;
   logic [7:0]  fetch_byte = 8'h00;
   logic [15:0] fetch_addr = 16'h0000;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [7:0]  dec_op;
   logic [7:0]  dec_disp;
   logic [15:0] dec_addr;
   logic        dec_len2;
   NEXTPC_t     dec_pc;
`ifdef SCMP_OPDEC_ILLEGAL_EN
   logic        dec_illegal;
`endif

   scmp_opdec_queue #(.DEPTH(2), .AW(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_byte  (fetch_byte),
      .fetch_addr  (fetch_addr),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_op      (dec_op),
      .dec_disp    (dec_disp),
      .dec_addr    (dec_addr),
      .dec_len2    (dec_len2),
      .dec_pc      (dec_pc)
`ifdef SCMP_OPDEC_ILLEGAL_EN
      ,
      .dec_illegal (dec_illegal)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Independent reference decode, written from the opcode table.
   function automatic NEXTPC_t ref_label(input logic [7:0] o);
      if (o == 8'h00) return UCLBL_HALT;
      if (o == 8'h8F) return UCLBL_DLY;
      if (o == 8'h01) return UCLBL_XAE;
      if (o[7:3] == 5'b11001 && o[2:0] != 3'b100) return UCLBL_ST;
      if (o[7:3] == 5'b11101) return UCLBL_DAD;
      if (o[7:6] == 2'b11) return UCLBL_LD;
      if (o == 8'h68) return UCLBL_DAE;
      if (o[7:6] == 2'b01 && o[2:0] == 3'b000) return UCLBL_LDE;
      if (o[7:2] == 6'b101010) return UCLBL_ILD;
      if (o[7:2] == 6'b101110) return UCLBL_DLD;
      if (o[7:4] == 4'b1001) return UCLBL_JMP;
      if (o[7:2] == 6'b001100) return UCLBL_XPAL;
      if (o[7:2] == 6'b001101) return UCLBL_XPAH;
      if (o[7:1] == 7'b0000001) return UCLBL_CL;
      return UCLBL_FETCH;
   endfunction

   typedef struct packed {
      logic [7:0]  op;
      logic [7:0]  disp;
      logic [15:0] addr;
      logic        len2;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   bit          m_st = 1'b0;
   logic [7:0]  m_op = 8'h00;
   logic [15:0] m_addr = 16'h0000;
   bit          rand_mode = 1'b0;
   bit          rdy_fixed = 1'b0;

   // Sequencer side: fixed or random dec_ready, changed just after each edge.
   always @(posedge clk) begin
      #1;
      dec_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
   end

   // Monitor + reference model, evaluated at the falling edge for the
   // upcoming rising edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("ready_in_rst", fetch_ready, 0);
         sb.delete();
         m_st = 1'b0;
      end else begin
         chk("ready", fetch_ready, (sb.size() < 2 && !flush));
         chk("valid", dec_valid, (sb.size() != 0));
         if (flush) begin
            sb.delete();
            m_st = 1'b0;
         end else begin
            if (dec_valid && dec_ready && sb.size() != 0) begin
               e = sb.pop_front();
               chk("op",   dec_op,   e.op);
               chk("disp", dec_disp, e.disp);
               chk("addr", dec_addr, e.addr);
               chk("len2", dec_len2, e.len2);
               chk("pc",   dec_pc,   ref_label(e.op));
`ifdef SCMP_OPDEC_ILLEGAL_EN
               chk("illegal", dec_illegal,
                   (ref_label(e.op) == UCLBL_FETCH) && (e.op != 8'h08));
`endif
            end
            if (fetch_valid && fetch_ready) begin
               if (!m_st) begin
                  if (fetch_byte[7]) begin
                     m_st   = 1'b1;
                     m_op   = fetch_byte;
                     m_addr = fetch_addr;
                  end else begin
                     sb.push_back('{op: fetch_byte, disp: 8'h00, addr: fetch_addr, len2: 1'b0});
                  end
               end else begin
                  sb.push_back('{op: m_op, disp: fetch_byte, addr: m_addr, len2: 1'b1});
                  m_st = 1'b0;
               end
            end
         end
      end
   end

   // Offer one byte; called just after a rising edge, returns just after the
   // rising edge that accepted it.
   task automatic send(input logic [7:0] b, input logic [15:0] a);
      bit done = 1'b0;
      fetch_byte  = b;
      fetch_addr  = a;
      fetch_valid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (fetch_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      fetch_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [7:0]  op;
      logic [15:0] a;

      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", dec_valid, 0);
      chk("rst_op",    dec_op,    0);
      chk("rst_disp",  dec_disp,  0);
      chk("rst_addr",  dec_addr,  0);
      chk("rst_len2",  dec_len2,  0);
      chk("rst_pc",    dec_pc,    UCLBL_FETCH);
`ifdef SCMP_OPDEC_ILLEGAL_EN
      chk("rst_illegal", dec_illegal, 0);
`endif
      @(posedge clk);
      #1;

      // Single- and two-byte instructions with the sequencer always ready.
      rdy_fixed = 1'b1;
      idle(1);
      send(8'h01, 16'h0010);
      @(negedge clk);
      chk("xae_lat_valid", dec_valid, 1);
      chk("xae_lat_pc",    dec_pc,    UCLBL_XAE);
      @(posedge clk);
      #1;
      send(8'hC4, 16'h0100);
      send(8'h55, 16'h0101);
      idle(4);

      // Full queue stalls fetch; drained in order once the sequencer is ready.
      rdy_fixed = 1'b0;
      idle(2);
      send(8'h08, 16'h0200);
      send(8'h30, 16'h0201);
      @(negedge clk);
      chk("full_stall", fetch_ready, 0);
      @(posedge clk);
      #1;
      fork
         send(8'h02, 16'h0202);
         begin
            idle(5);
            rdy_fixed = 1'b1;
         end
      join
      idle(6);

      // Flush right after a JMP opcode drops it; next entry is HALT.
      send(8'h90, 16'h0300);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      send(8'h00, 16'h0302);
      idle(4);

      // Flush with a full queue discards both entries.
      rdy_fixed = 1'b0;
      idle(2);
      send(8'h01, 16'h0310);
      send(8'h02, 16'h0311);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      @(negedge clk);
      chk("flush_empty", dec_valid, 0);
      @(posedge clk);
      #1;
      rdy_fixed = 1'b1;
      send(8'h30, 16'h0320);
      idle(4);

      // Unknown opcode vs NOP, then reset in the displacement state.
      send(8'h20, 16'h0330);
      send(8'h08, 16'h0331);
      idle(3);
      send(8'h94, 16'h0400);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", dec_valid, 0);
      @(posedge clk);
      #1;
      send(8'h01, 16'h0402);
      idle(4);

      // Mixed random stream with random sequencer backpressure.
      rand_mode = 1'b1;
      a = 16'h1000;
      for (int n = 0; n < 20; n++) begin
         op = 8'($urandom);
         if (n == 3) op = 8'h8F;
         if (n == 7) op = 8'hCC;
         if (n == 9) op = 8'h68;
         send(op, a);
         a = a + 16'd1;
         if (op[7]) begin
            send(8'($urandom), a);
            a = a + 16'd1;
         end
      end
      rand_mode = 1'b0;
      rdy_fixed = 1'b1;
      for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
      idle(2);
      chk("drain", sb.size(), 0);
      chk("drain_valid", dec_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
